wash_panel_ctrl: RTL and testbench

WASH_PANEL_CTRL -- requirements
Module: wash_panel_ctrl

---
 rtl/wash_panel_ctrl_if.sv | 24 ++
 rtl/wash_panel_ctrl.sv | 131 +++++++++++++
 tb/tb_wash_panel_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_panel_ctrl_if.sv
// Link between the wash panel and the downstream wash FSM: program code, start pulse,
// completion feedback and a debug view of the panel controller state.
interface wash_panel_ctrl_if;
  logic [2:0] program_selection;
  logic       start;
  logic       program_done;
  logic       state_dbg;

  // master = panel side (this block), slave = wash FSM side. start is a
  // single-cycle pulse; program_done is sampled only while the panel is running.
  modport master (
    output program_selection,
    output start,
    output state_dbg,
    input  program_done
  );

  modport slave (
    input  program_selection,
    input  start,
    input  state_dbg,
    output program_done
  );
endinterface

// File: rtl/wash_panel_ctrl.sv
// Washing-machine front panel: synchronizes and debounces four raw inputs, selects a
// program and issues a start pulse to the wash FSM while holding the door locked.
module wash_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic              start_btn_raw,
  input  logic              prog_btn_raw,
  input  logic              door_sw_raw,
  input  logic              soap_sw_raw,
  output logic              doorclosed,
  output logic              soap,
  output logic              door_lock,
  output logic              running,
  wash_panel_ctrl_if.master fsm_if
);

  localparam int         CH_START = 0;
  localparam int         CH_PROG  = 1;
  localparam int         CH_DOOR  = 2;
  localparam int         CH_SOAP  = 3;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  logic [3:0] raw_vec;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] deb_q;
  logic [3:0] deb_d;
  logic [3:0] rise_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  state_t     state_q;
  logic [2:0] sel_q;
  logic       start_q;
  logic       running_q;
  logic       lock_q;

  assign raw_vec = {soap_sw_raw, door_sw_raw, prog_btn_raw, start_btn_raw};

  // rise_d flags the cycle a debouncer is about to accept a new high level, so the
  // controller reacts on the same edge the debounced output changes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i]  = deb_q[i];
      cnt_d[i]  = cnt_q[i] + 8'd1;
      rise_d[i] = 1'b0;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i]  = sync2_q[i];
        cnt_d[i]  = 8'd0;
        rise_d[i] = sync2_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Loss of power aborts any run but keeps the chosen program.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 3'd0;
      start_q   <= 1'b0;
      running_q <= 1'b0;
      lock_q    <= 1'b0;
    end else if (!power) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      running_q <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          start_q <= 1'b0;
          if (rise_d[CH_START] && deb_q[CH_DOOR]) begin
            state_q   <= ST_RUNNING;
            start_q   <= 1'b1;
            running_q <= 1'b1;
            lock_q    <= 1'b1;
          end else if (rise_d[CH_PROG]) begin
            sel_q <= (sel_q == 3'd3) ? 3'd0 : sel_q + 3'd1;
          end
        end
        ST_RUNNING: begin
          start_q <= 1'b0;
          if (fsm_if.program_done) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            lock_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          start_q   <= 1'b0;
          running_q <= 1'b0;
          lock_q    <= 1'b0;
        end
      endcase
    end
  end

  assign doorclosed               = deb_q[CH_DOOR];
  assign soap                     = deb_q[CH_SOAP];
  assign door_lock                = lock_q;
  assign running                  = running_q;
  assign fsm_if.program_selection = sel_q;
  assign fsm_if.start             = start_q;
  assign fsm_if.state_dbg         = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Directed bench for wash_panel_ctrl with DEBOUNCE_CYCLES=4 and a 10 ns clock.
module tb_wash_panel_ctrl;

  logic clk;
  logic rst;
  logic power;
  logic start_btn_raw;
  logic prog_btn_raw;
  logic door_sw_raw;
  logic soap_sw_raw;
  logic doorclosed;
  logic soap;
  logic door_lock;
  logic running;

  int checks;
  int errors;
  int start_pulses;

  wash_panel_ctrl_if wif ();

  wash_panel_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .power         (power),
    .start_btn_raw (start_btn_raw),
    .prog_btn_raw  (prog_btn_raw),
    .door_sw_raw   (door_sw_raw),
    .soap_sw_raw   (soap_sw_raw),
    .doorclosed    (doorclosed),
    .soap          (soap),
    .door_lock     (door_lock),
    .running       (running),
    .fsm_if        (wif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && wif.start) start_pulses++;
  end

  // ---------------- vector record ----------------
  typedef struct {
    string      name;
    logic       pwr;
    logic       start_b;
    logic       prog_b;
    logic       door_b;
    logic       soap_b;
    logic       done;
    int         cycles;
    logic [2:0] exp_sel;
    logic       exp_run;
    logic       exp_door;
    logic       exp_soap;
    int         exp_starts;
  } vec_t;

  vec_t vecs [$];

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string name, input logic pwr, input logic sb, input logic pb,
                         input logic db, input logic ob, input logic dn, input int cyc,
                         input logic [2:0] es, input logic er, input logic ed,
                         input logic eo, input int est);
    vec_t v;
    v.name = name; v.pwr = pwr; v.start_b = sb; v.prog_b = pb; v.door_b = db;
    v.soap_b = ob; v.done = dn; v.cycles = cyc; v.exp_sel = es; v.exp_run = er;
    v.exp_door = ed; v.exp_soap = eo; v.exp_starts = est;
    vecs.push_back(v);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_state(input string name, input logic [2:0] es);
    chk({name, "_sel"}, {5'd0, wif.program_selection}, {5'd0, es});
    chk({name, "_run"}, {7'd0, running}, 8'd0);
    chk({name, "_lock"}, {7'd0, door_lock}, 8'd0);
  endtask

  task automatic run_program();
    start_btn_raw = 1'b1;
    wait_neg(10);
    start_btn_raw = 1'b0;
    wait_neg(10);
  endtask

  task automatic done_pulse();
    wif.program_done = 1'b1;
    wait_neg(1);
    wif.program_done = 1'b0;
  endtask

  // ---------------- main test ----------------
  initial begin
    checks = 0; errors = 0; start_pulses = 0;
    rst = 1'b0; power = 1'b1;
    start_btn_raw = 1'b0; prog_btn_raw = 1'b0; door_sw_raw = 1'b0; soap_sw_raw = 1'b0;
    wif.program_done = 1'b0;

    wait_neg(3);
    check_idle_state("reset", 3'd0);
    chk("reset_start", {7'd0, wif.start}, 8'd0);
    chk("reset_door", {7'd0, doorclosed}, 8'd0);
    chk("reset_soap", {7'd0, soap}, 8'd0);
    rst = 1'b1;
    wait_neg(2);

    //      name          pwr st pg dr sp dn cyc sel  run dr sp starts
    add_vec("door_close",  1, 0, 0, 1, 0, 0, 10, 3'd0, 0, 1, 0, 0);
    add_vec("prog1_dn",    1, 0, 1, 1, 0, 0, 10, 3'd1, 0, 1, 0, 0);
    add_vec("prog1_up",    1, 0, 0, 1, 0, 0, 10, 3'd1, 0, 1, 0, 0);
    add_vec("prog2_dn",    1, 0, 1, 1, 0, 0, 10, 3'd2, 0, 1, 0, 0);
    add_vec("prog2_up",    1, 0, 0, 1, 0, 0, 10, 3'd2, 0, 1, 0, 0);
    add_vec("prog3_dn",    1, 0, 1, 1, 0, 0, 10, 3'd3, 0, 1, 0, 0);
    add_vec("prog3_up",    1, 0, 0, 1, 0, 0, 10, 3'd3, 0, 1, 0, 0);
    add_vec("prog4_wrap",  1, 0, 1, 1, 0, 0, 10, 3'd0, 0, 1, 0, 0);
    add_vec("prog4_up",    1, 0, 0, 1, 0, 0, 10, 3'd0, 0, 1, 0, 0);
    add_vec("soap_on",     1, 0, 0, 1, 1, 0, 10, 3'd0, 0, 1, 1, 0);
    add_vec("start_run",   1, 1, 0, 1, 1, 0, 10, 3'd0, 1, 1, 1, 1);
    add_vec("run_prog",    1, 0, 1, 1, 1, 0, 10, 3'd0, 1, 1, 1, 1);
    add_vec("run_start",   1, 1, 0, 1, 1, 0, 10, 3'd0, 1, 1, 1, 1);
    add_vec("done_level",  1, 0, 0, 1, 1, 1, 10, 3'd0, 0, 1, 1, 1);
    add_vec("done_clr",    1, 0, 0, 1, 1, 0, 10, 3'd0, 0, 1, 1, 1);
    add_vec("door_open",   1, 0, 0, 0, 1, 0, 10, 3'd0, 0, 0, 1, 1);
    add_vec("open_start",  1, 1, 0, 0, 1, 0, 10, 3'd0, 0, 0, 1, 1);
    add_vec("open_rel",    1, 0, 0, 0, 1, 0, 10, 3'd0, 0, 0, 1, 1);
    add_vec("close_noq",   1, 0, 0, 1, 1, 0, 10, 3'd0, 0, 1, 1, 1);
    add_vec("nopwr_start", 0, 1, 0, 1, 1, 0, 10, 3'd0, 0, 1, 1, 1);
    add_vec("pwr_back",    1, 0, 0, 1, 1, 0, 10, 3'd0, 0, 1, 1, 1);

    foreach (vecs[i]) begin
      power            = vecs[i].pwr;
      start_btn_raw    = vecs[i].start_b;
      prog_btn_raw     = vecs[i].prog_b;
      door_sw_raw      = vecs[i].door_b;
      soap_sw_raw      = vecs[i].soap_b;
      wif.program_done = vecs[i].done;
      wait_neg(vecs[i].cycles);
      chk({vecs[i].name, "_sel"}, {5'd0, wif.program_selection}, {5'd0, vecs[i].exp_sel});
      chk({vecs[i].name, "_run"}, {7'd0, running}, {7'd0, vecs[i].exp_run});
      chk({vecs[i].name, "_lock"}, {7'd0, door_lock}, {7'd0, vecs[i].exp_run});
      chk({vecs[i].name, "_door"}, {7'd0, doorclosed}, {7'd0, vecs[i].exp_door});
      chk({vecs[i].name, "_soap"}, {7'd0, soap}, {7'd0, vecs[i].exp_soap});
      chk_int({vecs[i].name, "_starts"}, start_pulses, vecs[i].exp_starts);
    end

    // Start and prog pressed together: start pulse lands exactly 6 edges later, selection unchanged.
    start_btn_raw = 1'b1;
    prog_btn_raw  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_neg(1);
      chk($sformatf("lat_start_k%0d", k), {7'd0, wif.start}, {7'd0, (k == 6)});
      chk($sformatf("lat_run_k%0d", k), {7'd0, running}, {7'd0, (k >= 6)});
    end
    chk("both_sel", {5'd0, wif.program_selection}, 8'd0);
    start_btn_raw = 1'b0;
    prog_btn_raw  = 1'b0;
    wait_neg(10);
    done_pulse();
    chk("done_run", {7'd0, running}, 8'd0);
    chk("done_lock", {7'd0, door_lock}, 8'd0);
    chk_int("both_starts", start_pulses, 2);
    wait_neg(2);

    // 3-cycle glitch is rejected; a 4-cycle press is the shortest accepted.
    start_btn_raw = 1'b1;
    wait_neg(3);
    start_btn_raw = 1'b0;
    wait_neg(10);
    chk_int("glitch_starts", start_pulses, 2);
    chk("glitch_run", {7'd0, running}, 8'd0);
    start_btn_raw = 1'b1;
    wait_neg(4);
    start_btn_raw = 1'b0;
    wait_neg(10);
    chk_int("press4_starts", start_pulses, 3);
    chk("press4_run", {7'd0, running}, 8'd1);
    done_pulse();
    wait_neg(2);

    // Power loss while running.
    prog_btn_raw = 1'b1;
    wait_neg(10);
    prog_btn_raw = 1'b0;
    wait_neg(10);
    chk("sel_before_pwr", {5'd0, wif.program_selection}, 8'd1);
    run_program();
    chk("pwr_pre_run", {7'd0, running}, 8'd1);
    power = 1'b0;
    wait_neg(1);
    check_idle_state("pwr_drop", 3'd1);
    chk("pwr_dbg", {7'd0, wif.state_dbg}, 8'd0);
    power = 1'b1;
    wait_neg(2);
    chk_int("pwr_starts", start_pulses, 4);

    // Asynchronous reset mid-run, then soap (held high) reappears 6 edges after release.
    run_program();
    chk("rst_pre_run", {7'd0, running}, 8'd1);
    #2 rst = 1'b0;
    #1;
    check_idle_state("rst_async", 3'd0);
    chk("rst_async_soap", {7'd0, soap}, 8'd0);
    chk("rst_async_door", {7'd0, doorclosed}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      wait_neg(1);
      chk($sformatf("rel_soap_k%0d", k), {7'd0, soap}, {7'd0, (k >= 6)});
    end
    chk("rel_door", {7'd0, doorclosed}, 8'd1);
    check_idle_state("rel_idle", 3'd0);
    chk_int("rst_starts", start_pulses, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
